instr_fetch_unit: RTL and testbench

//  Fetch stage directly downstream of the program counter. Takes each PC from the PC

---
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage behind the PC register: issues an imem read per accepted PC and buffers
// up to DEPTH fetches in order. It hands {instruction, PC} to decode, and flush drops all work.
module instr_fetch_unit #(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] PC,
    input  logic         pc_valid,
    output logic         pc_ready,
    input  logic         flush,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [N-1:0] imem_req_addr,
    input  logic         imem_rsp_valid,
    input  logic [31:0]  imem_rsp_data,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [31:0]  inst_out,
    output logic [N-1:0] inst_pc,
    output logic         protocol_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [N-1:0]     pc_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [PW-1:0]    alloc_ptr_q, fill_ptr_q, head_ptr_q;
    logic [CW-1:0]    alloc_cnt_q, alloc_cnt_d;
    logic [CW-1:0]    pend_cnt_q, pend_cnt_d;
    logic [CW-1:0]    drop_cnt_q, drop_cnt_d;
    logic             protocol_err_q, protocol_err_d;

    logic [CW:0] occ;
    logic        accept, pop, rsp_drop, rsp_fill, rsp_err;

    // Credits come from registered occupancy only, so a pop never frees a slot in the same cycle.
    assign occ            = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
    assign imem_req_valid = pc_valid & !flush & (occ < DEPTH_W);
    assign pc_ready       = imem_req_valid & imem_req_ready;
    assign imem_req_addr  = {PC[N-1:2], 2'b00};
    assign accept         = pc_valid & pc_ready;

    assign inst_valid   = filled_q[head_ptr_q] & !flush;
    assign inst_out     = data_q[head_ptr_q];
    assign inst_pc      = pc_q[head_ptr_q];
    assign protocol_err = protocol_err_q;
    assign pop          = inst_valid & inst_ready;

    assign rsp_drop = imem_rsp_valid & (drop_cnt_q != '0);
    assign rsp_fill = imem_rsp_valid & (drop_cnt_q == '0) & (pend_cnt_q != '0);
    assign rsp_err  = imem_rsp_valid & (drop_cnt_q == '0) & (pend_cnt_q == '0);

    always_comb begin
        // NOTE: every _d gets its default first so no path through this block infers a latch.
        alloc_cnt_d    = alloc_cnt_q;
        pend_cnt_d     = pend_cnt_q;
        drop_cnt_d     = drop_cnt_q;
        protocol_err_d = protocol_err_q;
        if (flush) begin
            alloc_cnt_d = '0;
            pend_cnt_d  = '0;
            drop_cnt_d  = pend_cnt_q + drop_cnt_q;
            if (imem_rsp_valid) begin
                if (drop_cnt_d != '0) drop_cnt_d = drop_cnt_d - CW'(1);
                else                  protocol_err_d = 1'b1;
            end
        end else begin
            alloc_cnt_d = alloc_cnt_q + CW'(accept) - CW'(pop);
            pend_cnt_d  = pend_cnt_q + CW'(accept) - CW'(rsp_fill);
            drop_cnt_d  = drop_cnt_q - CW'(rsp_drop);
            if (rsp_err) protocol_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the small entry array is reset as well, so inst_out/inst_pc read 0 out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
            filled_q       <= '0;
            alloc_ptr_q    <= '0;
            fill_ptr_q     <= '0;
            head_ptr_q     <= '0;
            alloc_cnt_q    <= '0;
            pend_cnt_q     <= '0;
            drop_cnt_q     <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            alloc_cnt_q    <= alloc_cnt_d;
            pend_cnt_q     <= pend_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
            protocol_err_q <= protocol_err_d;
            if (flush) begin
                filled_q    <= '0;
                alloc_ptr_q <= '0;
                fill_ptr_q  <= '0;
                head_ptr_q  <= '0;
            end else begin
                // Accept, fill and pop always touch distinct entries, so all three may apply at once.
                if (accept) begin
                    pc_q[alloc_ptr_q]     <= PC;
                    filled_q[alloc_ptr_q] <= 1'b0;
                    alloc_ptr_q           <= alloc_ptr_q + PW'(1);
                end
                if (rsp_fill) begin
                    data_q[fill_ptr_q]   <= imem_rsp_data;
                    filled_q[fill_ptr_q] <= 1'b1;
                    fill_ptr_q           <= fill_ptr_q + PW'(1);
                end
                if (pop) begin
                    filled_q[head_ptr_q] <= 1'b0;
                    head_ptr_q           <= head_ptr_q + PW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetch sequences against a queued
// memory model. A negedge monitor compares every delivered instruction.
module tb_instr_fetch_unit;
    logic        clk;
    logic        rst;
    logic [31:0] PC;
    logic        pc_valid, pc_ready, flush;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_out, inst_pc;
    logic        protocol_err;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_q[$];
    exp_t        mon_e;
    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          mem_en;
    int          mem_credit;
    bit          spurious;

    instr_fetch_unit #(.N(32), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .PC             (PC),
        .pc_valid       (pc_valid),
        .pc_ready       (pc_ready),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .protocol_err   (protocol_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: requests captured before the accepting edge, answered in order
    // from the next cycle on, as far as mem_en / mem_credit allow.
    always @(negedge clk)
        if (rst && imem_req_valid && imem_req_ready) mem_q.push_back(imem_req_addr);

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                mem_q.delete();
                imem_rsp_valid = 1'b0;
            end else if (spurious) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
                spurious       = 1'b0;
            end else if (mem_q.size() > 0 && (mem_en || mem_credit > 0)) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_q.pop_front());
                if (mem_credit > 0) mem_credit--;
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    // Monitor: every decode handshake must match the oldest expected pair.
    always @(negedge clk) begin
        if (rst && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_inst: got pc=%h data=%h, none expected", inst_pc, inst_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("inst_pc", {32'h0, inst_pc}, {32'h0, mon_e.pc});
                check("inst_out", {32'h0, inst_out}, {32'h0, mon_e.data});
            end
        end
    end

    // Called and returning at posedge+1; holds PC until accepted.
    task automatic fetch(input logic [31:0] a, input bit expect_out);
        int n = 0;
        PC       = a;
        pc_valid = 1'b1;
        @(negedge clk);
        while (!pc_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!pc_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL fetch_accept: pc %h not accepted, expected accept within 50 cycles", a);
        end else if (expect_out) begin
            exp_q.push_back({a, mem_word(a)});
        end
        @(posedge clk);
        #1;
        pc_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d outputs outstanding, expected 0 after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; PC = '0; pc_valid = 1'b0; flush = 1'b0;
        imem_req_ready = 1'b1; inst_ready = 1'b0;
        mem_en = 1'b1; mem_credit = 0; spurious = 1'b0;
        #2;
        check("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
        check("rst_inst_out", {32'h0, inst_out}, 64'h0);
        check("rst_inst_pc", {32'h0, inst_pc}, 64'h0);
        check("rst_protocol_err", {63'h0, protocol_err}, 64'h0);
        check("rst_pc_ready", {63'h0, pc_ready}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // 1: request gating by imem_req_ready, address alignment, streaming fetch.
        PC = 32'h13; pc_valid = 1'b1; imem_req_ready = 1'b0;
        @(negedge clk);
        check("req_valid_unready", {63'h0, imem_req_valid}, 64'h1);
        check("pc_ready_unready", {63'h0, pc_ready}, 64'h0);
        check("req_addr_align", {32'h0, imem_req_addr}, 64'h10);
        @(posedge clk);
        #1;
        pc_valid = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
        fetch(32'h0, 1'b1);
        fetch(32'h4, 1'b1);
        fetch(32'h8, 1'b1);
        wait_drain(20);

        // 2: latency, backpressure when full, stable head, order after release.
        inst_ready = 1'b0;
        fetch(32'h0, 1'b1);
        @(negedge clk);
        check("lat_rsp_cycle_valid", {63'h0, inst_valid}, 64'h0);
        @(negedge clk);
        check("lat_first_valid", {63'h0, inst_valid}, 64'h1);
        check("lat_first_pc", {32'h0, inst_pc}, 64'h0);
        @(posedge clk);
        #1;
        fetch(32'h4, 1'b1);
        PC = 32'h8; pc_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("full_pc_ready", {63'h0, pc_ready}, 64'h0);
            check("full_req_valid", {63'h0, imem_req_valid}, 64'h0);
            check("hold_inst_pc", {32'h0, inst_pc}, 64'h0);
            check("hold_inst_out", {32'h0, inst_out}, 64'hC0DE_0000);
            @(posedge clk);
            #1;
        end
        pc_valid = 1'b0; inst_ready = 1'b1;
        wait_drain(20);

        // 3: two in flight, flush pulse, both old responses dropped.
        mem_en = 1'b0;
        fetch(32'h0, 1'b0);
        fetch(32'h4, 1'b0);
        flush = 1'b1; PC = 32'h100; pc_valid = 1'b1;
        @(negedge clk);
        check("flush_req_valid", {63'h0, imem_req_valid}, 64'h0);
        check("flush_pc_ready", {63'h0, pc_ready}, 64'h0);
        @(posedge clk);
        #1;
        flush = 1'b0; mem_en = 1'b1; pc_valid = 1'b0;
        fetch(32'h100, 1'b1);
        wait_drain(20);
        check("flush_no_err", {63'h0, protocol_err}, 64'h0);

        // 4: flush in the same cycle as a response, one drop remains.
        mem_en = 1'b0;
        fetch(32'h200, 1'b0);
        fetch(32'h204, 1'b0);
        flush = 1'b1; mem_credit = 1;
        @(negedge clk);
        check("flush_rsp_inst_valid", {63'h0, inst_valid}, 64'h0);
        @(posedge clk);
        #1;
        flush = 1'b0; mem_en = 1'b1;
        fetch(32'h300, 1'b1);
        wait_drain(20);
        check("flush_rsp_no_err", {63'h0, protocol_err}, 64'h0);

        // 5: response with nothing outstanding sets a sticky error.
        spurious = 1'b1;
        @(negedge clk);
        check("spur_err_before", {63'h0, protocol_err}, 64'h0);
        check("spur_inst_valid", {63'h0, inst_valid}, 64'h0);
        @(negedge clk);
        check("spur_err_set", {63'h0, protocol_err}, 64'h1);
        @(posedge clk);
        #1;
        fetch(32'h10, 1'b1);
        wait_drain(20);
        check("spur_err_sticky", {63'h0, protocol_err}, 64'h1);

        // 6: asynchronous reset with filled entries, then restart.
        inst_ready = 1'b0;
        fetch(32'h40, 1'b0);
        fetch(32'h44, 1'b0);
        @(negedge clk);
        check("pre_rst_valid", {63'h0, inst_valid}, 64'h1);
        check("pre_rst_pc", {32'h0, inst_pc}, 64'h40);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", {63'h0, inst_valid}, 64'h0);
        check("async_rst_out", {32'h0, inst_out}, 64'h0);
        check("async_rst_pc", {32'h0, inst_pc}, 64'h0);
        check("async_rst_err", {63'h0, protocol_err}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; inst_ready = 1'b1;
        fetch(32'h0, 1'b1);
        fetch(32'h4, 1'b1);
        wait_drain(20);
        check("restart_no_err", {63'h0, protocol_err}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
